hazard_scoreboard: RTL and testbench

- Parametrised scoreboard for the dual-issue front end. It tracks outstanding long-latency writebacks, detects RAW and WAW hazards for two in-order issue slots (A older, B younger), and allocates commit IDs.
- It adds the following over the previous hazard unit:
  - configurable depth and commit-port count;
  - strict in-order issue (B never issues without A);
  - a drain FSM for serialising instructions (CSR/fence);
  - pipeline flush;
  - occupancy count;
  - a sticky error flag for illegal commits.
- Sits between decode and issue; commit ports are driven by the writeback arbiter.

---
 rtl/hazard_scoreboard_if.sv | 45 ++++
 rtl/hazard_scoreboard.sv | 164 ++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// Decode/issue-side bundle for the hazard scoreboard: slot descriptors and
// commit strobes flow into the scoreboard, issue grants and status flow out.
interface hazard_scoreboard_if #(
  parameter int DEPTH      = 8,
  parameter int ID_W       = $clog2(DEPTH),
  parameter int REG_ADDR_W = 5,
  parameter int NCOMMIT    = 2
);
  logic                    flush_i;
  logic                    a_valid_i,  b_valid_i;
  logic [REG_ADDR_W-1:0]   a_rs1_i,    a_rs2_i,    a_rd_i;
  logic [REG_ADDR_W-1:0]   b_rs1_i,    b_rs2_i,    b_rd_i;
  logic                    a_rd_we_i,  b_rd_we_i;
  logic                    a_long_i,   b_long_i;
  logic                    a_serial_i, b_serial_i;
  logic                    a_ctrl_i;
  logic [NCOMMIT-1:0]      commit_valid_i;
  logic [NCOMMIT*ID_W-1:0] commit_id_i;
  logic [1:0]              issue_o;
  logic                    stall_o;
  logic [ID_W-1:0]         a_id_o, b_id_o;
  logic [ID_W:0]           count_o;
  logic                    busy_o;
  logic                    err_o;

  // Decode / writeback-arbiter side.
  modport master (
    output flush_i, a_valid_i, b_valid_i,
    output a_rs1_i, a_rs2_i, a_rd_i, b_rs1_i, b_rs2_i, b_rd_i,
    output a_rd_we_i, b_rd_we_i, a_long_i, b_long_i,
    output a_serial_i, b_serial_i, a_ctrl_i,
    output commit_valid_i, commit_id_i,
    input  issue_o, stall_o, a_id_o, b_id_o, count_o, busy_o, err_o
  );

  // Scoreboard side.
  modport slave (
    input  flush_i, a_valid_i, b_valid_i,
    input  a_rs1_i, a_rs2_i, a_rd_i, b_rs1_i, b_rs2_i, b_rd_i,
    input  a_rd_we_i, b_rd_we_i, a_long_i, b_long_i,
    input  a_serial_i, b_serial_i, a_ctrl_i,
    input  commit_valid_i, commit_id_i,
    output issue_o, stall_o, a_id_o, b_id_o, count_o, busy_o, err_o
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Dual-issue hazard scoreboard: tracks outstanding long-latency writebacks,
// blocks RAW/WAW hazards for in-order slots A (older) and B (younger),
// hands out commit IDs, drains before serialising instructions and flushes.
module hazard_scoreboard #(
  parameter int DEPTH      = 8,
  parameter int ID_W       = $clog2(DEPTH),
  parameter int REG_ADDR_W = 5,
  parameter int NCOMMIT    = 2
) (
  input logic               clk,
  input logic               rst_n,
  hazard_scoreboard_if.slave sb
);

  typedef enum logic [0:0] {ST_RUN, ST_DRAIN} state_e;

  state_e                state_q, state_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [REG_ADDR_W-1:0] rd_q [DEPTH];
  logic [REG_ADDR_W-1:0] rd_d [DEPTH];
  logic [ID_W:0]         count_q, count_d;
  logic                  err_q, err_d;

  logic [DEPTH-1:0]      commit_hit, live;
  logic                  bad_commit;
  logic [ID_W:0]         clr_cnt, free_cnt, need_b;
  logic                  haz_a, haz_b, alloc_a, alloc_b;
  logic                  issue_a, issue_b;
  logic [ID_W-1:0]       a_free, b_free;
  logic                  a_found, b_found;

  // True when a live entry will write register r (x0 never conflicts).
  function automatic logic live_match(input logic [REG_ADDR_W-1:0] r);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (live[i] && rd_q[i] == r) hit = 1'b1;
    return hit && (r != '0);
  endfunction

  // Decode commit ports: which entries retire this cycle, and any illegal commit.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    commit_hit = '0;
    bad_commit = 1'b0;
    clr_cnt    = '0;
    for (int p = 0; p < NCOMMIT; p++) begin
      if (sb.commit_valid_i[p]) begin
        commit_hit[sb.commit_id_i[p*ID_W +: ID_W]] = 1'b1;
        if (!valid_q[sb.commit_id_i[p*ID_W +: ID_W]]) bad_commit = 1'b1;
      end
    end
    live = valid_q & ~commit_hit;
    for (int i = 0; i < DEPTH; i++)
      if (valid_q[i] && commit_hit[i]) clr_cnt = clr_cnt + (ID_W+1)'(1);
  end

  // Lowest free IDs, taken from registered valid bits only (freed IDs wait a cycle).
  always_comb begin
    a_free  = '0;
    a_found = 1'b0;
    b_free  = '0;
    b_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !a_found) begin
        a_free  = ID_W'(i);
        a_found = 1'b1;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !b_found && !(alloc_a && ID_W'(i) == a_free)) begin
        b_free  = ID_W'(i);
        b_found = 1'b1;
      end
    end
  end

  // Hazard detection, resource check and issue decision for both slots.
  always_comb begin
    alloc_a  = sb.a_long_i & sb.a_rd_we_i & (sb.a_rd_i != '0);
    alloc_b  = sb.b_long_i & sb.b_rd_we_i & (sb.b_rd_i != '0);
    free_cnt = (ID_W+1)'(DEPTH) - count_q;
    need_b   = (ID_W+1)'(alloc_a) + (ID_W+1)'(alloc_b);

    haz_a = live_match(sb.a_rs1_i) | live_match(sb.a_rs2_i)
          | (sb.a_rd_we_i & live_match(sb.a_rd_i));

    // B is also held behind A's destination, a branch in A, or any serialising slot.
    haz_b = live_match(sb.b_rs1_i) | live_match(sb.b_rs2_i)
          | (sb.b_rd_we_i & live_match(sb.b_rd_i))
          | (sb.a_rd_we_i & (sb.a_rd_i != '0) &
             ((sb.b_rs1_i == sb.a_rd_i) | (sb.b_rs2_i == sb.a_rd_i) |
              (sb.b_rd_we_i & (sb.b_rd_i == sb.a_rd_i))))
          | sb.a_ctrl_i | sb.b_serial_i | sb.a_serial_i;

    issue_a = sb.a_valid_i & ~haz_a & (~alloc_a | (free_cnt != '0))
            & (state_q == ST_RUN) & (~sb.a_serial_i | (count_q == '0))
            & ~sb.flush_i;
    issue_b = issue_a & sb.b_valid_i & ~haz_b & (free_cnt >= need_b);
  end

  // Next entry table, occupancy, error flag and drain FSM.
  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    count_d = count_q;
    err_d   = err_q;
    state_d = state_q;
    if (sb.flush_i) begin
      valid_d = '0;
      count_d = '0;
      state_d = ST_RUN;
    end else begin
      valid_d = valid_q & ~commit_hit;
      err_d   = err_q | bad_commit;
      if (issue_a && alloc_a) begin
        valid_d[a_free] = 1'b1;
        rd_d[a_free]    = sb.a_rd_i;
      end
      if (issue_b && alloc_b) begin
        valid_d[b_free] = 1'b1;
        rd_d[b_free]    = sb.b_rd_i;
      end
      count_d = count_q + (ID_W+1)'(issue_a & alloc_a)
              + (ID_W+1)'(issue_b & alloc_b) - clr_cnt;
      case (state_q)
        ST_RUN:   if (sb.a_valid_i && sb.a_serial_i && count_q != '0) state_d = ST_DRAIN;
        ST_DRAIN: if (count_q == '0) state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      state_q <= ST_RUN;
      valid_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Destination register storage.
  always_ff @(posedge clk) begin
    // NOTE: rd storage needs no reset; an entry's rd is only read while its valid bit is set.
    for (int i = 0; i < DEPTH; i++) rd_q[i] <= rd_d[i];
  end

  assign sb.issue_o = {issue_b, issue_a};
  assign sb.stall_o = sb.a_valid_i & (~issue_a | (sb.b_valid_i & ~issue_b));
  assign sb.a_id_o  = (issue_a && alloc_a) ? a_free : '0;
  assign sb.b_id_o  = (issue_b && alloc_b) ? b_free : '0;
  assign sb.count_o = count_q;
  assign sb.busy_o  = (count_q != '0);
  assign sb.err_o   = err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_hazard_scoreboard;
  localparam int DEPTH = 8;
  localparam int ID_W  = 3;
  localparam int RW    = 5;
  localparam int NC    = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.DEPTH(DEPTH), .ID_W(ID_W), .REG_ADDR_W(RW), .NCOMMIT(NC)) sb_if ();

  hazard_scoreboard #(.DEPTH(DEPTH), .ID_W(ID_W), .REG_ADDR_W(RW), .NCOMMIT(NC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sb_if)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: a table of outstanding writes plus a drain flag.
  bit          m_valid [DEPTH];
  logic [RW-1:0] m_rd  [DEPTH];
  bit          m_err;
  bit          m_drain;

  logic [1:0]      e_issue;
  logic            e_stall;
  logic [ID_W-1:0] e_aid, e_bid;
  int              e_count;
  bit              e_alloc_a, e_alloc_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit m_committing(int i);
    for (int p = 0; p < NC; p++)
      if (sb_if.commit_valid_i[p] && int'(sb_if.commit_id_i[p*ID_W +: ID_W]) == i) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_pending_write(logic [RW-1:0] r);
    if (r == 0) return 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (m_valid[i] && !m_committing(i) && m_rd[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_eval();
    int  free_list[$];
    bit  haz_a, haz_b, can_a, can_b;
    logic [RW-1:0] a_dst;
    free_list = {};
    for (int i = 0; i < DEPTH; i++) if (!m_valid[i]) free_list.push_back(i);
    e_count   = DEPTH - free_list.size();
    e_alloc_a = sb_if.a_long_i && sb_if.a_rd_we_i && sb_if.a_rd_i != 0;
    e_alloc_b = sb_if.b_long_i && sb_if.b_rd_we_i && sb_if.b_rd_i != 0;
    haz_a = m_pending_write(sb_if.a_rs1_i) || m_pending_write(sb_if.a_rs2_i) ||
            (sb_if.a_rd_we_i && m_pending_write(sb_if.a_rd_i));
    a_dst = sb_if.a_rd_we_i ? sb_if.a_rd_i : '0;
    haz_b = m_pending_write(sb_if.b_rs1_i) || m_pending_write(sb_if.b_rs2_i) ||
            (sb_if.b_rd_we_i && m_pending_write(sb_if.b_rd_i)) ||
            (a_dst != 0 && (sb_if.b_rs1_i == a_dst || sb_if.b_rs2_i == a_dst ||
                            (sb_if.b_rd_we_i && sb_if.b_rd_i == a_dst))) ||
            sb_if.a_ctrl_i || sb_if.b_serial_i || sb_if.a_serial_i;
    can_a = sb_if.a_valid_i && !haz_a && (!e_alloc_a || free_list.size() >= 1) &&
            !m_drain && (!sb_if.a_serial_i || e_count == 0) && !sb_if.flush_i;
    can_b = can_a && sb_if.b_valid_i && !haz_b &&
            free_list.size() >= int'(e_alloc_a) + int'(e_alloc_b);
    e_issue = {can_b, can_a};
    e_stall = sb_if.a_valid_i && (!can_a || (sb_if.b_valid_i && !can_b));
    e_aid = (can_a && e_alloc_a) ? ID_W'(free_list[0]) : '0;
    e_bid = '0;
    if (can_b && e_alloc_b) e_bid = e_alloc_a ? ID_W'(free_list[1]) : ID_W'(free_list[0]);
  endtask

  task automatic model_update();
    bit clr [DEPTH];
    int id;
    model_eval();
    if (sb_if.flush_i) begin
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
      m_drain = 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) clr[i] = 1'b0;
      for (int p = 0; p < NC; p++) begin
        if (sb_if.commit_valid_i[p]) begin
          id = int'(sb_if.commit_id_i[p*ID_W +: ID_W]);
          if (m_valid[id]) clr[id] = 1'b1;
          else m_err = 1'b1;
        end
      end
      for (int i = 0; i < DEPTH; i++) if (clr[i]) m_valid[i] = 1'b0;
      if (e_issue[0] && e_alloc_a) begin m_valid[e_aid] = 1'b1; m_rd[e_aid] = sb_if.a_rd_i; end
      if (e_issue[1] && e_alloc_b) begin m_valid[e_bid] = 1'b1; m_rd[e_bid] = sb_if.b_rd_i; end
      if (m_drain) begin
        if (e_count == 0) m_drain = 1'b0;
      end else if (sb_if.a_valid_i && sb_if.a_serial_i && e_count != 0) begin
        m_drain = 1'b1;
      end
    end
  endtask

  // Compare every DUT output against the model.
  task automatic compare();
    model_eval();
    check("issue_o", 32'(sb_if.issue_o), 32'(e_issue));
    check("stall_o", 32'(sb_if.stall_o), 32'(e_stall));
    check("a_id_o",  32'(sb_if.a_id_o),  32'(e_aid));
    check("b_id_o",  32'(sb_if.b_id_o),  32'(e_bid));
    check("count_o", 32'(sb_if.count_o), 32'(e_count));
    check("busy_o",  32'(sb_if.busy_o),  32'(e_count != 0));
    check("err_o",   32'(sb_if.err_o),   32'(m_err));
  endtask

  task automatic settle();
    @(negedge clk);
    compare();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    sb_if.flush_i = 0;
    sb_if.a_valid_i = 0; sb_if.a_rs1_i = 0; sb_if.a_rs2_i = 0; sb_if.a_rd_i = 0;
    sb_if.a_rd_we_i = 0; sb_if.a_long_i = 0; sb_if.a_serial_i = 0; sb_if.a_ctrl_i = 0;
    sb_if.b_valid_i = 0; sb_if.b_rs1_i = 0; sb_if.b_rs2_i = 0; sb_if.b_rd_i = 0;
    sb_if.b_rd_we_i = 0; sb_if.b_long_i = 0; sb_if.b_serial_i = 0;
    sb_if.commit_valid_i = 0; sb_if.commit_id_i = 0;
  endtask

  task automatic set_a(input bit v, input int rs1, input int rs2, input int rd,
                       input bit we, input bit lng, input bit ser, input bit ctl);
    sb_if.a_valid_i = v; sb_if.a_rs1_i = RW'(rs1); sb_if.a_rs2_i = RW'(rs2);
    sb_if.a_rd_i = RW'(rd); sb_if.a_rd_we_i = we; sb_if.a_long_i = lng;
    sb_if.a_serial_i = ser; sb_if.a_ctrl_i = ctl;
  endtask

  task automatic set_b(input bit v, input int rs1, input int rs2, input int rd,
                       input bit we, input bit lng, input bit ser);
    sb_if.b_valid_i = v; sb_if.b_rs1_i = RW'(rs1); sb_if.b_rs2_i = RW'(rs2);
    sb_if.b_rd_i = RW'(rd); sb_if.b_rd_we_i = we; sb_if.b_long_i = lng;
    sb_if.b_serial_i = ser;
  endtask

  task automatic commit(input bit v0, input int id0, input bit v1, input int id1);
    sb_if.commit_valid_i = {v1, v0};
    sb_if.commit_id_i    = {ID_W'(id1), ID_W'(id0)};
  endtask

  task automatic reset_dut();
    idle();
    rst_n = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin m_valid[i] = 1'b0; m_rd[i] = '0; end
    m_err = 1'b0; m_drain = 1'b0;
    #2;
    check("rst_count", 32'(sb_if.count_o), 0);
    check("rst_err",   32'(sb_if.err_o),   0);
    check("rst_issue", 32'(sb_if.issue_o), 0);
    check("rst_stall", 32'(sb_if.stall_o), 0);
    check("rst_ids",   32'({sb_if.a_id_o, sb_if.b_id_o}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pick;
    int vl[$];

    // 1: RAW on a pending long write, commit bypass
    reset_dut();
    set_a(1, 0, 0, 5, 1, 1, 0, 0); set_b(1, 5, 0, 0, 0, 0, 0);
    settle();
    check("t1_issue", 32'(sb_if.issue_o), 1);
    check("t1_aid",   32'(sb_if.a_id_o), 0);
    check("t1_stall", 32'(sb_if.stall_o), 1);
    tick(); idle();
    set_a(1, 5, 0, 0, 0, 0, 0, 0);
    settle(); check("t1_raw_hold", 32'(sb_if.issue_o), 0);
    tick();
    commit(1, 0, 0, 0);
    settle(); check("t1_bypass", 32'(sb_if.issue_o[0]), 1);
    tick(); idle();
    settle(); check("t1_count_after", 32'(sb_if.count_o), 0);
    tick();

    // 2: full table, reuse of a freed ID one cycle after its commit
    reset_dut();
    for (int k = 0; k < 4; k++) begin
      set_a(1, 0, 0, 2*k+1, 1, 1, 0, 0); set_b(1, 0, 0, 2*k+2, 1, 1, 0);
      settle(); check("t2_fill_issue", 32'(sb_if.issue_o), 3);
      tick();
    end
    idle(); set_a(1, 0, 0, 9, 1, 1, 0, 0);
    settle();
    check("t2_full_count", 32'(sb_if.count_o), 8);
    check("t2_full_block", 32'(sb_if.issue_o), 0);
    tick();
    commit(1, 3, 0, 0);
    settle(); check("t2_commit_cycle", 32'(sb_if.issue_o), 0);
    tick(); commit(0, 0, 0, 0);
    settle();
    check("t2_reuse_issue", 32'(sb_if.issue_o), 1);
    check("t2_reuse_id",    32'(sb_if.a_id_o), 3);
    tick(); idle();
    settle(); check("t2_count_stays", 32'(sb_if.count_o), 8);
    tick();

    // 3: serialising instruction drains the table first
    reset_dut();
    set_a(1, 0, 0, 1, 1, 1, 0, 0); set_b(1, 0, 0, 2, 1, 1, 0);
    settle(); tick(); idle();
    set_a(1, 0, 0, 0, 0, 0, 1, 0);
    settle(); check("t3_enter_drain", 32'(sb_if.issue_o), 0);
    tick();
    commit(1, 0, 1, 1);
    settle(); check("t3_drain_hold", 32'(sb_if.issue_o), 0);
    tick(); commit(0, 0, 0, 0);
    settle();
    check("t3_count_zero", 32'(sb_if.count_o), 0);
    check("t3_drain_exit", 32'(sb_if.issue_o), 0);
    tick();
    set_b(1, 3, 4, 5, 1, 0, 0);
    settle(); check("t3_serial_alone", 32'(sb_if.issue_o), 1);
    tick(); idle();

    // 4: flush with a simultaneous commit; 5: sticky error
    reset_dut();
    for (int k = 0; k < 2; k++) begin
      set_a(1, 0, 0, 2*k+1, 1, 1, 0, 0); set_b(1, 0, 0, 2*k+2, 1, 1, 0);
      settle(); tick();
    end
    idle();
    sb_if.flush_i = 1; commit(1, 1, 0, 0); set_a(1, 0, 0, 5, 1, 1, 0, 0);
    settle(); check("t4_flush_issue", 32'(sb_if.issue_o), 0);
    tick(); idle();
    settle();
    check("t4_count", 32'(sb_if.count_o), 0);
    check("t4_busy",  32'(sb_if.busy_o), 0);
    check("t4_err",   32'(sb_if.err_o), 0);
    tick();
    commit(1, 6, 0, 0);
    settle(); tick(); idle();
    settle();
    check("t5_err_set",   32'(sb_if.err_o), 1);
    check("t5_count_same", 32'(sb_if.count_o), 0);
    tick();
    set_a(1, 0, 0, 3, 1, 1, 0, 0);
    settle(); tick(); idle();
    commit(1, 0, 0, 0);
    settle(); tick(); idle();
    settle();
    check("t5_err_sticky", 32'(sb_if.err_o), 1);
    check("t5_count_back", 32'(sb_if.count_o), 0);
    tick();

    // 6: branch in A holds B; WAW in A holds both
    reset_dut();
    set_a(1, 0, 0, 7, 1, 1, 0, 0);
    settle(); tick();
    set_a(1, 1, 2, 10, 1, 0, 0, 1); set_b(1, 11, 12, 13, 1, 0, 0);
    settle(); check("t6_branch", 32'(sb_if.issue_o), 1);
    tick();
    set_a(1, 0, 0, 7, 1, 0, 0, 0);
    settle();
    check("t6_waw_issue", 32'(sb_if.issue_o), 0);
    check("t6_waw_stall", 32'(sb_if.stall_o), 1);
    tick(); idle();

    // Randomized traffic against the model
    reset_dut();
    for (int n = 0; n < 3000; n++) begin
      idle();
      sb_if.flush_i = ($urandom_range(0, 99) < 2);
      set_a($urandom_range(0, 99) < 85, $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 9), $urandom_range(0, 1), $urandom_range(0, 99) < 60,
            $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 15);
      set_b($urandom_range(0, 99) < 80, $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 9), $urandom_range(0, 1), $urandom_range(0, 99) < 60,
            $urandom_range(0, 99) < 4);
      vl = {};
      for (int i = 0; i < DEPTH; i++) if (m_valid[i]) vl.push_back(i);
      for (int p = 0; p < NC; p++) begin
        if ($urandom_range(0, 99) < 35) begin
          if (vl.size() != 0 && $urandom_range(0, 99) < 97)
            pick = vl[$urandom_range(0, vl.size() - 1)];
          else
            pick = $urandom_range(0, DEPTH - 1);
          sb_if.commit_valid_i[p] = 1'b1;
          sb_if.commit_id_i[p*ID_W +: ID_W] = ID_W'(pick);
        end
      end
      settle();
      tick();
    end
    idle();
    settle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
